// File: rtl/vga_fb_arbiter.sv
`timescale 1ns/1ps
// Single-port framebuffer arbiter: display reads have strict priority, the CPU
// uses idle cycles, and read returns are steered by a tag pipeline.
module vga_fb_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 8,
  parameter int RAM_LAT      = 1,
  parameter int STARVE_LIMIT = 800
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_rvalid,
  output logic [DATA_W-1:0] o_disp_rdata,
  input  logic              i_cpu_valid,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ready,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_starve
);
  localparam int TAG_D = RAM_LAT + 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic              grant_disp, grant_cpu, push_read;
  logic              ret_vld, ret_cpu;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [TAG_D-1:0]  tag_vld_q, tag_vld_d, tag_cpu_q, tag_cpu_d;
  logic              disp_rvalid_q, disp_rvalid_d, cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d, cpu_rdata_q, cpu_rdata_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              starve_q, starve_d;

  assign grant_disp  = i_disp_req;
  assign grant_cpu   = i_cpu_valid & ~i_disp_req;
  assign push_read   = grant_disp | (grant_cpu & ~i_cpu_we);
  assign o_cpu_ready = grant_cpu;

  // The display carries no write data, so a display grant leaves wdata as is.
  always_comb begin
    ram_en_d    = grant_disp | grant_cpu;
    ram_we_d    = grant_cpu & i_cpu_we;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (grant_disp) begin
      ram_addr_d = i_disp_addr;
    end else if (grant_cpu) begin
      ram_addr_d  = i_cpu_addr;
      ram_wdata_d = i_cpu_wdata;
    end
  end

  // Tag entry 0 is loaded at the grant edge; the last entry selects the return port.
  always_comb begin
    tag_vld_d = {tag_vld_q[TAG_D-2:0], push_read};
    tag_cpu_d = {tag_cpu_q[TAG_D-2:0], grant_cpu};
  end

  assign ret_vld = tag_vld_q[TAG_D-1];
  assign ret_cpu = tag_cpu_q[TAG_D-1];

  always_comb begin
    disp_rvalid_d = ret_vld & ~ret_cpu;
    cpu_rvalid_d  = ret_vld & ret_cpu;
    disp_rdata_d  = disp_rdata_q;
    cpu_rdata_d   = cpu_rdata_q;
    if (disp_rvalid_d) disp_rdata_d = i_ram_rdata;
    if (cpu_rvalid_d)  cpu_rdata_d  = i_ram_rdata;
  end

  // Starve flag follows the next counter value so it rises on the limit edge.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_cpu_valid || grant_cpu) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    starve_d = (starve_cnt_d == CNT_MAX);
  end

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      tag_vld_q     <= '0;
      tag_cpu_q     <= '0;
      disp_rvalid_q <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      disp_rdata_q  <= '0;
      cpu_rdata_q   <= '0;
      starve_cnt_q  <= '0;
      starve_q      <= 1'b0;
    end else begin
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      tag_vld_q     <= tag_vld_d;
      tag_cpu_q     <= tag_cpu_d;
      disp_rvalid_q <= disp_rvalid_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      disp_rdata_q  <= disp_rdata_d;
      cpu_rdata_q   <= cpu_rdata_d;
      starve_cnt_q  <= starve_cnt_d;
      starve_q      <= starve_d;
    end
  end

  assign o_ram_en      = ram_en_q;
  assign o_ram_we      = ram_we_q;
  assign o_ram_addr    = ram_addr_q;
  assign o_ram_wdata   = ram_wdata_q;
  assign o_disp_rvalid = disp_rvalid_q;
  assign o_disp_rdata  = disp_rdata_q;
  assign o_cpu_rvalid  = cpu_rvalid_q;
  assign o_cpu_rdata   = cpu_rdata_q;
  assign o_starve      = starve_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
`timescale 1ns/1ps
// Bench for vga_fb_arbiter: two instances (RAM_LAT 1 and 3) share one stimulus
// stream; a transaction-log reference model predicts every output.
module tb_vga_fb_arbiter;
  localparam int AW   = 15;
  localparam int DW   = 8;
  localparam int SL   = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_req, cpu_valid, cpu_we;
  logic [AW-1:0] disp_addr, cpu_addr;
  logic [DW-1:0] cpu_wdata;

  logic          disp_rv [2];
  logic          cpu_rv  [2];
  logic          ready   [2];
  logic          ram_en  [2];
  logic          ram_we  [2];
  logic          starve  [2];
  logic [AW-1:0] ram_addr [2];
  logic [DW-1:0] disp_rd [2];
  logic [DW-1:0] cpu_rd  [2];
  logic [DW-1:0] ram_wd  [2];
  logic [DW-1:0] ram_rd  [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? LAT0 : LAT1;
    bit [DW-1:0] mem   [0:(1<<AW)-1];
    bit          wrote [0:(1<<AW)-1];
    bit [DW-1:0] stg   [L];

    // RAM with L-cycle read latency; unwritten words read as addr+0x10.
    always @(negedge clk) begin
      if (ram_en[gi] && ram_we[gi]) begin
        mem[ram_addr[gi]]   <= ram_wd[gi];
        wrote[ram_addr[gi]] <= 1'b1;
      end
      if (ram_en[gi] && !ram_we[gi])
        stg[0] <= wrote[ram_addr[gi]] ? mem[ram_addr[gi]] : DW'(int'(ram_addr[gi]) + 16);
      else
        stg[0] <= 8'hEE;
      for (int j = 1; j < L; j++) stg[j] <= stg[j-1];
    end
    assign ram_rd[gi] = stg[L-1];

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(L), .STARVE_LIMIT(SL)) u_dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_disp_req   (disp_req),
      .i_disp_addr  (disp_addr),
      .o_disp_rvalid(disp_rv[gi]),
      .o_disp_rdata (disp_rd[gi]),
      .i_cpu_valid  (cpu_valid),
      .i_cpu_we     (cpu_we),
      .i_cpu_addr   (cpu_addr),
      .i_cpu_wdata  (cpu_wdata),
      .o_cpu_ready  (ready[gi]),
      .o_cpu_rvalid (cpu_rv[gi]),
      .o_cpu_rdata  (cpu_rd[gi]),
      .o_ram_en     (ram_en[gi]),
      .o_ram_we     (ram_we[gi]),
      .o_ram_addr   (ram_addr[gi]),
      .o_ram_wdata  (ram_wd[gi]),
      .i_ram_rdata  (ram_rd[gi]),
      .o_starve     (starve[gi])
    );
  end

  // Reference model: every read is logged with its issue edge; instance i
  // returns it lat_of(i)+1 edges later, in issue order.
  typedef struct {
    int          issue;
    bit          cpu;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          log_q[$];
  int            rd_ptr [2];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic          exp_drv [2];
  logic          exp_crv [2];
  logic [DW-1:0] exp_drd [2];
  logic [DW-1:0] exp_crd [2];
  logic          exp_en, exp_we, exp_starve;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;
  int            run, cyc;
  bit            last_xfer;
  int            checks, errors;

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      exp_drv[i] = 1'b0; exp_crv[i] = 1'b0;
      exp_drd[i] = '0;   exp_crd[i] = '0;
      rd_ptr[i]  = log_q.size();
    end
    exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    run = 0; exp_starve = 1'b0; last_xfer = 1'b0;
  endtask

  task automatic model_edge();
    ret_t r;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      exp_drv[i] = 1'b0;
      exp_crv[i] = 1'b0;
      if (rd_ptr[i] < log_q.size() && log_q[rd_ptr[i]].issue + lat_of(i) + 1 == cyc) begin
        r = log_q[rd_ptr[i]];
        rd_ptr[i]++;
        if (r.cpu) begin exp_crv[i] = 1'b1; exp_crd[i] = r.data; end
        else       begin exp_drv[i] = 1'b1; exp_drd[i] = r.data; end
      end
    end
    last_xfer = 1'b0;
    if (disp_req) begin
      r.issue = cyc; r.cpu = 1'b0; r.data = shadow[disp_addr];
      log_q.push_back(r);
      exp_en = 1'b1; exp_we = 1'b0; exp_addr = disp_addr;
    end else if (cpu_valid) begin
      last_xfer = 1'b1;
      exp_en = 1'b1; exp_we = cpu_we; exp_addr = cpu_addr;
      if (cpu_we) begin
        shadow[cpu_addr] = cpu_wdata;
        exp_wd = cpu_wdata;
      end else begin
        r.issue = cyc; r.cpu = 1'b1; r.data = shadow[cpu_addr];
        log_q.push_back(r);
      end
    end else begin
      exp_en = 1'b0; exp_we = 1'b0;
    end
    if (cpu_valid && disp_req) run++;
    else run = 0;
    exp_starve = (run >= SL);
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("g%0d.disp_rvalid", i), disp_rv[i], exp_drv[i]);
      chk($sformatf("g%0d.cpu_rvalid", i), cpu_rv[i], exp_crv[i]);
      chk($sformatf("g%0d.disp_rdata", i), disp_rd[i], exp_drd[i]);
      chk($sformatf("g%0d.cpu_rdata", i), cpu_rd[i], exp_crd[i]);
      chk($sformatf("g%0d.ram_en", i), ram_en[i], exp_en);
      chk($sformatf("g%0d.ram_we", i), ram_we[i], exp_we);
      chk($sformatf("g%0d.ram_addr", i), ram_addr[i], exp_addr);
      if (exp_we) chk($sformatf("g%0d.ram_wdata", i), ram_wd[i], exp_wd);
      chk($sformatf("g%0d.starve", i), starve[i], exp_starve);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s g%0d.disp_rvalid", tag, i), disp_rv[i], 1'b0);
      chk($sformatf("%s g%0d.cpu_rvalid", tag, i), cpu_rv[i], 1'b0);
      chk($sformatf("%s g%0d.disp_rdata", tag, i), disp_rd[i], 8'h00);
      chk($sformatf("%s g%0d.cpu_rdata", tag, i), cpu_rd[i], 8'h00);
      chk($sformatf("%s g%0d.ram_en", tag, i), ram_en[i], 1'b0);
      chk($sformatf("%s g%0d.ram_we", tag, i), ram_we[i], 1'b0);
      chk($sformatf("%s g%0d.ram_addr", tag, i), ram_addr[i], 15'h0);
      chk($sformatf("%s g%0d.ram_wdata", tag, i), ram_wd[i], 8'h00);
      chk($sformatf("%s g%0d.starve", tag, i), starve[i], 1'b0);
      chk($sformatf("%s g%0d.cpu_ready", tag, i), ready[i], 1'b0);
    end
  endtask

  // One clock: check the combinational ready, apply the edge, check registered outputs.
  task automatic tick();
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("g%0d.cpu_ready", i), ready[i], cpu_valid & ~disp_req);
    @(negedge clk);
    model_edge();
    @(posedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    disp_req = 1'b0; disp_addr = '0;
    cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    for (int a = 0; a < (1 << AW); a++) shadow[a] = DW'(a + 16);
    model_clear();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    $display("reset released, all outputs zero");

    for (int a = 0; a < 8; a++) begin
      disp_req = 1'b1; disp_addr = AW'(a);
      tick();
    end
    idle_inputs();
    repeat (5) tick();
    $display("display stream of 8 reads at 0..7");

    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 8'hA5;
    tick();
    idle_inputs();
    repeat (5) tick();
    $display("cpu write 0xA5 -> 0x1234");

    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0040;
    for (int k = 0; k < 3; k++) begin
      disp_req = 1'b1; disp_addr = AW'($urandom_range(0, 63));
      tick();
    end
    disp_req = 1'b0;
    tick();
    idle_inputs();
    repeat (5) tick();
    $display("collision: cpu read 0x0040 held behind 3 display reads");

    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) begin
        disp_req = 1'b1; disp_addr = AW'($urandom_range(0, 31)); cpu_valid = 1'b0;
      end else begin
        disp_req = 1'b0; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = AW'($urandom_range(0, 31));
      end
      tick();
    end
    idle_inputs();
    repeat (5) tick();
    $display("interleaved display/cpu reads, 16 cycles");

    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0005; cpu_wdata = DW'($urandom);
    disp_req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      disp_addr = AW'($urandom_range(0, 31));
      tick();
    end
    disp_req = 1'b0;
    tick();
    idle_inputs();
    repeat (3) tick();
    $display("starvation: 7 stalled edges then transfer");

    for (int k = 0; k < 300; k++) begin
      if (last_xfer) cpu_valid = 1'b0;
      if (!cpu_valid && $urandom_range(0, 1) == 1) begin
        cpu_valid = 1'b1;
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = AW'($urandom_range(0, 31));
        cpu_wdata = DW'($urandom);
      end
      disp_req  = $urandom_range(0, 99) < 55;
      disp_addr = AW'($urandom_range(0, 31));
      tick();
    end
    idle_inputs();
    repeat (5) tick();
    $display("random mixed traffic, 300 cycles");

    disp_req = 1'b1; disp_addr = 15'h0003;
    tick();
    disp_req = 1'b0; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0009;
    tick();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    model_clear();
    @(negedge clk);
    cyc++;
    @(posedge clk);
    check_all_zero("midreset_hold");
    rst_n = 1'b1;
    repeat (8) tick();
    $display("mid-flight reset, no stale returns after release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
